alu_sequencer: RTL and testbench

- Control/issue stage directly upstream of the 8-bit add/sub ALU.
- Accepts one instruction per valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU operand, control and enable inputs, then consumes the ALU's registered result and flags.
- Writes the result back and holds flag copies for downstream logic.
- This is the sequential front end the ALU needs to execute programs.

---
 rtl/alu_sequencer_if.sv | 39 +++
 rtl/alu_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU drive/return, flag and debug signals between the
// instruction source / ALU environment (master) and the sequencer (slave).
interface alu_sequencer_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned REG_ADDR_WIDTH = 2
);
    logic                      instrValid;
    logic                      instrReady;
    logic [1:0]                instrOp;
    logic [REG_ADDR_WIDTH-1:0] instrRd;
    logic [REG_ADDR_WIDTH-1:0] instrRs;
    logic [DATA_WIDTH-1:0]     instrImm;
    logic [DATA_WIDTH-1:0]     aluOperand1;
    logic [DATA_WIDTH-1:0]     aluOperand2;
    logic                      aluControl;
    logic                      aluEnable;
    logic [DATA_WIDTH-1:0]     aluResult;
    logic                      aluZero;
    logic                      aluOverflow;
    logic                      zeroFlag;
    logic                      carryFlag;
    logic                      done;
    logic [REG_ADDR_WIDTH-1:0] dbgAddr;
    logic [DATA_WIDTH-1:0]     dbgData;

    modport master (
        output instrValid, instrOp, instrRd, instrRs, instrImm,
               aluResult, aluZero, aluOverflow, dbgAddr,
        input  instrReady, aluOperand1, aluOperand2, aluControl, aluEnable,
               zeroFlag, carryFlag, done, dbgData
    );

    modport slave (
        input  instrValid, instrOp, instrRd, instrRs, instrImm,
               aluResult, aluZero, aluOverflow, dbgAddr,
        output instrReady, aluOperand1, aluOperand2, aluControl, aluEnable,
               zeroFlag, carryFlag, done, dbgData
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer for the 8-bit add/sub ALU: small register file,
// serial IDLE -> ISSUE -> WRITEBACK flow, latched zero/carry flags.
module alu_sequencer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned REG_ADDR_WIDTH = 2
) (
    input  logic           clock,
    input  logic           resetN,
    alu_sequencer_if.slave bus
);
    localparam int unsigned NUM_REGS = 1 << REG_ADDR_WIDTH;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WRITEBACK = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [1:0]                op_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]     regs [NUM_REGS];

    logic accept;
    logic load_ldi;
    logic load_alu;
    logic ready_next;
    logic enable_next;
    logic done_next;

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        load_ldi    = 1'b0;
        load_alu    = 1'b0;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.instrValid && bus.instrReady) begin
                    accept = 1'b1;
                    if (bus.instrOp == OP_LDI) begin
                        load_ldi  = 1'b1;
                        done_next = 1'b1;
                    end else begin
                        load_alu   = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE:     state_next = WRITEBACK;
            WRITEBACK: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default:   state_next = IDLE;
        endcase
        ready_next  = (state_next == IDLE);
        enable_next = (state_next == ISSUE);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake, ALU drive and latched instruction fields.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            bus.instrReady  <= 1'b1;
            bus.aluEnable   <= 1'b0;
            bus.aluControl  <= 1'b1;
            bus.aluOperand1 <= '0;
            bus.aluOperand2 <= '0;
            bus.done        <= 1'b0;
            op_q            <= OP_ADD;
            rd_q            <= '0;
        end else begin
            bus.instrReady <= ready_next;
            bus.aluEnable  <= enable_next;
            bus.done       <= done_next;
            if (accept) begin
                op_q <= bus.instrOp;
                rd_q <= bus.instrRd;
            end
            // Operands are sampled at the accept edge so they are stable for the whole ISSUE cycle.
            if (load_alu) begin
                bus.aluOperand1 <= regs[bus.instrRd];
                bus.aluOperand2 <= regs[bus.instrRs];
                bus.aluControl  <= (bus.instrOp == OP_ADD);
            end
        end
    end

    // Register file and flags.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            bus.zeroFlag  <= 1'b0;
            bus.carryFlag <= 1'b0;
        end else begin
            if (load_ldi) begin
                regs[bus.instrRd] <= bus.instrImm;
            end
            if (state == WRITEBACK) begin
                if (op_q != OP_CMP) begin
                    regs[rd_q] <= bus.aluResult;
                end
                bus.zeroFlag  <= bus.aluZero;
                bus.carryFlag <= bus.aluOverflow;
            end
        end
    end

    assign bus.dbgData = regs[bus.dbgAddr];

    logic unused_ok;
    assign unused_ok = (op_q == OP_SUB);
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 9-bit add/sub ALU attached.
module tb_alu_sequencer;
    logic clock;
    logic resetN;
    int   total;
    int   bad;
    int   en_count;

    alu_sequencer_if #(.DATA_WIDTH(8), .REG_ADDR_WIDTH(2)) bus ();

    alu_sequencer #(.DATA_WIDTH(8), .REG_ADDR_WIDTH(2)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Registered ALU: captures {carry, result} and 9-bit zero when enabled.
    function automatic logic [8:0] alu9(input logic ctrl, input logic [7:0] a, input logic [7:0] b);
        return ctrl ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
    endfunction

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            bus.aluResult   <= 8'h00;
            bus.aluOverflow <= 1'b0;
            bus.aluZero     <= 1'b0;
        end else if (bus.aluEnable) begin
            bus.aluResult   <= alu9(bus.aluControl, bus.aluOperand1, bus.aluOperand2)[7:0];
            bus.aluOverflow <= alu9(bus.aluControl, bus.aluOperand1, bus.aluOperand2)[8];
            bus.aluZero     <= (alu9(bus.aluControl, bus.aluOperand1, bus.aluOperand2) == 9'd0);
        end
    end

    always @(posedge clock) begin
        if (bus.aluEnable) en_count <= en_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input logic [1:0] addr, input logic [7:0] exp);
        bus.dbgAddr = addr;
        #1;
        check($sformatf("reg_r%0d", addr), 32'(bus.dbgData), 32'(exp));
    endtask

    // Present an LDI; leaves instrValid high so a following LDI is back-to-back.
    task automatic ldi(input logic [1:0] rd, input logic [7:0] imm);
        bus.instrOp    = 2'b10;
        bus.instrRd    = rd;
        bus.instrRs    = 2'd0;
        bus.instrImm   = imm;
        bus.instrValid = 1'b1;
        @(posedge clock); #1;
        check("ldi_done", 32'(bus.done), 32'd1);
        check("ldi_ready", 32'(bus.instrReady), 32'd1);
    endtask

    task automatic alu_op(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                          input logic [7:0] e1, input logic [7:0] e2, input logic ec,
                          input bit hold);
        int en0;
        en0 = en_count;
        bus.instrOp    = op;
        bus.instrRd    = rd;
        bus.instrRs    = rs;
        bus.instrImm   = 8'hA5;
        bus.instrValid = 1'b1;
        check("acc_ready", 32'(bus.instrReady), 32'd1);
        @(posedge clock); #1;
        if (!hold) bus.instrValid = 1'b0;
        check("iss_en", 32'(bus.aluEnable), 32'd1);
        check("iss_ctrl", 32'(bus.aluControl), 32'(ec));
        check("iss_op1", 32'(bus.aluOperand1), 32'(e1));
        check("iss_op2", 32'(bus.aluOperand2), 32'(e2));
        check("iss_ready", 32'(bus.instrReady), 32'd0);
        @(posedge clock); #1;
        check("wb_en", 32'(bus.aluEnable), 32'd0);
        check("wb_done", 32'(bus.done), 32'd0);
        check("wb_ready", 32'(bus.instrReady), 32'd0);
        @(posedge clock); #1;
        bus.instrValid = 1'b0;
        check("ret_done", 32'(bus.done), 32'd1);
        check("ret_ready", 32'(bus.instrReady), 32'd1);
        check("en_pulses", 32'(en_count - en0), 32'd1);
    endtask

    task automatic check_flags(input logic z, input logic c);
        check("zero_flag", 32'(bus.zeroFlag), 32'(z));
        check("carry_flag", 32'(bus.carryFlag), 32'(c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        en_count = 0;
        resetN = 1'b0;
        bus.instrValid = 1'b0;
        bus.instrOp = 2'b00;
        bus.instrRd = 2'd0;
        bus.instrRs = 2'd0;
        bus.instrImm = 8'h00;
        bus.dbgAddr = 2'd0;
        #12;
        check("rst_ready", 32'(bus.instrReady), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_en", 32'(bus.aluEnable), 32'd0);
        check("rst_ctrl", 32'(bus.aluControl), 32'd1);
        check_flags(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_reg(2'(i), 8'h00);
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock); #1;
        check("idle_done", 32'(bus.done), 32'd0);

        // Back-to-back LDIs retire on consecutive cycles.
        ldi(2'd0, 8'h05);
        ldi(2'd1, 8'h03);
        bus.instrValid = 1'b0;
        check_reg(2'd0, 8'h05);
        check_reg(2'd1, 8'h03);
        check_flags(1'b0, 1'b0);
        @(posedge clock); #1;
        check("ldi_idle_done", 32'(bus.done), 32'd0);

        alu_op(2'b00, 2'd0, 2'd1, 8'h05, 8'h03, 1'b1, 1'b0);
        check_reg(2'd0, 8'h08);
        check_flags(1'b0, 1'b0);

        // 0xFF + 0x01 = 0x100: low byte zero but carry, so zeroFlag stays 0.
        ldi(2'd2, 8'hFF);
        ldi(2'd3, 8'h01);
        alu_op(2'b00, 2'd2, 2'd3, 8'hFF, 8'h01, 1'b1, 1'b0);
        check_reg(2'd2, 8'h00);
        check_flags(1'b0, 1'b1);

        alu_op(2'b01, 2'd1, 2'd1, 8'h03, 8'h03, 1'b0, 1'b0);
        check_reg(2'd1, 8'h00);
        check_flags(1'b1, 1'b0);

        alu_op(2'b11, 2'd0, 2'd2, 8'h08, 8'h00, 1'b0, 1'b0);
        check_reg(2'd0, 8'h08);
        check_flags(1'b0, 1'b0);

        // 0x02 - 0x05 borrows; instrValid held through ISSUE/WRITEBACK.
        ldi(2'd0, 8'h02);
        ldi(2'd1, 8'h05);
        alu_op(2'b01, 2'd0, 2'd1, 8'h02, 8'h05, 1'b0, 1'b1);
        check_reg(2'd0, 8'hFD);
        check_flags(1'b0, 1'b1);
        @(posedge clock); #1;
        check("hold_no_extra_done", 32'(bus.done), 32'd0);
        check("hold_no_extra_en", 32'(bus.aluEnable), 32'd0);

        // ADD r1,r3 aborted by reset during WRITEBACK.
        bus.instrOp = 2'b00;
        bus.instrRd = 2'd1;
        bus.instrRs = 2'd3;
        bus.instrValid = 1'b1;
        @(posedge clock); #1;
        bus.instrValid = 1'b0;
        check("abort_iss_en", 32'(bus.aluEnable), 32'd1);
        @(posedge clock); #1;
        check("abort_wb_ready", 32'(bus.instrReady), 32'd0);
        resetN = 1'b0;
        #1;
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_ready", 32'(bus.instrReady), 32'd1);
        check("abort_en", 32'(bus.aluEnable), 32'd0);
        check_flags(1'b0, 1'b0);
        @(posedge clock); #1;
        check("abort_hold_done", 32'(bus.done), 32'd0);
        resetN = 1'b1;
        @(posedge clock); #1;
        check("post_rst_done", 32'(bus.done), 32'd0);
        check("post_rst_ready", 32'(bus.instrReady), 32'd1);
        for (int i = 0; i < 4; i++) check_reg(2'(i), 8'h00);
        check_flags(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
